// File: rtl/approx_error_monitor.sv
// approx_error_monitor
// Sequential characterisation checker for an approximate WIDTHxWIDTH
// multiplier. Each accepted triple (a, b, approx) is re-multiplied exactly
// with a one-bit-per-cycle shift-add datapath, then the error distance
// |exact - approx| is folded into saturating statistics.
// Optional feature: define ERR_BIAS_EN to add the signed err_bias output,
// a saturating sum of (exact - approx).
module approx_error_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [2*WIDTH-1:0]   in_product,
  input  logic                 clear,
  output logic                 busy,
  output logic [CNT_W-1:0]     sample_count,
  output logic [CNT_W-1:0]     error_count,
  output logic [ACC_W-1:0]     ed_sum,
  output logic [2*WIDTH-1:0]   ed_max,
  output logic [2*WIDTH-1:0]   last_ed
`ifdef ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0] err_bias
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CMP  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;
  logic   r_busy;

  // Shift-add datapath registers.
  logic [PW-1:0]    r_a;
  logic [WIDTH-1:0] r_b;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_approx;
  logic [CW-1:0]    r_cnt;

  // Statistic registers.
  logic [CNT_W-1:0] r_sample_count;
  logic [CNT_W-1:0] r_error_count;
  logic [ACC_W-1:0] r_ed_sum;
  logic [PW-1:0]    r_ed_max;
  logic [PW-1:0]    r_last_ed;

  // Combinational compare-stage values.
  logic [PW-1:0]    w_ed;
  logic [ACC_W:0]   w_sum_wide;
  logic [ACC_W-1:0] w_sum_nxt;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    logic [CNT_W-1:0] res;
    if (&v) begin
      res = v;
    end else begin
      res = v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  assign in_ready     = (r_state == S_IDLE);
  assign busy         = r_busy;
  assign sample_count = r_sample_count;
  assign error_count  = r_error_count;
  assign ed_sum       = r_ed_sum;
  assign ed_max       = r_ed_max;
  assign last_ed      = r_last_ed;

  // Next-state logic: accept in IDLE, run WIDTH MUL steps, one CMP step; clear aborts.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_MUL;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_MUL: begin
        if (clear) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_ONE) begin
          w_state_nxt = S_CMP;
        end else begin
          w_state_nxt = S_MUL;
        end
      end
      S_CMP: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Capture triple in IDLE, then one shift-add step per MUL cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= {PW{1'b0}};
      r_b      <= {WIDTH{1'b0}};
      r_acc    <= {PW{1'b0}};
      r_approx <= {PW{1'b0}};
      r_cnt    <= {CW{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= {{WIDTH{1'b0}}, in_a};
            r_b      <= in_b;
            r_acc    <= {PW{1'b0}};
            r_approx <= in_product;
            r_cnt    <= CNT_LOAD;
          end
        end
        S_MUL: begin
          if (r_b[0]) begin
            r_acc <= r_acc + r_a;
          end
          r_a   <= {r_a[PW-2:0], 1'b0};
          r_b   <= {1'b0, r_b[WIDTH-1:1]};
          r_cnt <= r_cnt - CNT_ONE;
        end
        default: begin
        end
      endcase
    end
  end

  // Error distance and saturating running sum of it.
  always_comb begin
    if (r_acc >= r_approx) begin
      w_ed = r_acc - r_approx;
    end else begin
      w_ed = r_approx - r_acc;
    end
    w_sum_wide = {1'b0, r_ed_sum} + {{(ACC_W + 1 - PW){1'b0}}, w_ed};
    if (w_sum_wide[ACC_W]) begin
      w_sum_nxt = {ACC_W{1'b1}};
    end else begin
      w_sum_nxt = w_sum_wide[ACC_W-1:0];
    end
  end

  // Statistics: rst beats clear, clear beats the CMP update.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_sample_count <= {CNT_W{1'b0}};
      r_error_count  <= {CNT_W{1'b0}};
      r_ed_sum       <= {ACC_W{1'b0}};
      r_ed_max       <= {PW{1'b0}};
      r_last_ed      <= {PW{1'b0}};
    end else if (r_state == S_CMP) begin
      r_sample_count <= sat_inc(r_sample_count);
      if (w_ed != {PW{1'b0}}) begin
        r_error_count <= sat_inc(r_error_count);
      end
      r_ed_sum  <= w_sum_nxt;
      if (w_ed > r_ed_max) begin
        r_ed_max <= w_ed;
      end
      r_last_ed <= w_ed;
    end
  end

`ifdef ERR_BIAS_EN
  logic [PW:0]            w_diff;
  logic [ACC_W+1:0]       w_bias_wide;
  logic [ACC_W:0]         w_bias_nxt;
  logic signed [ACC_W:0]  r_err_bias;

  assign err_bias = r_err_bias;

  // Signed exact-minus-approx, added with one guard bit and clamped on overflow.
  always_comb begin
    w_diff      = {1'b0, r_acc} - {1'b0, r_approx};
    w_bias_wide = {r_err_bias[ACC_W], r_err_bias}
                + {{(ACC_W + 1 - PW){w_diff[PW]}}, w_diff};
    if (w_bias_wide[ACC_W+1] != w_bias_wide[ACC_W]) begin
      if (w_bias_wide[ACC_W+1]) begin
        w_bias_nxt = {1'b1, {ACC_W{1'b0}}};
      end else begin
        w_bias_nxt = {1'b0, {ACC_W{1'b1}}};
      end
    end else begin
      w_bias_nxt = w_bias_wide[ACC_W:0];
    end
  end

  // Bias accumulator follows the same reset/clear/CMP priority as the statistics.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_err_bias <= {(ACC_W + 1){1'b0}};
    end else if (r_state == S_CMP) begin
      r_err_bias <= w_bias_nxt;
    end
  end
`endif

endmodule
